// File: rtl/pattern_source_scorer.sv
// pattern_source_scorer: programmable serial pattern source with prediction scoring.
// Holds up to DEPTH bits, plays them out one per clock as actual_pattern and
// counts how many cycles the predictor's pred_bit matched the played bit.
module pattern_source_scorer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load_en,
    input  logic                       load_bit,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       pred_bit,
    output logic                       actual_pattern,
    output logic                       valid,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] len,
    output logic [CNT_W-1:0]           bit_cnt,
    output logic [CNT_W-1:0]           hit_cnt
);

    localparam int unsigned      LEN_W = $clog2(DEPTH + 1);
    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] FULL  = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             cur_bit;
    logic             hit;
    logic             last_bit;
    logic             start_go;

    // The write pointer doubles as the stored length.
    assign rd_idx         = rd_ptr_q[PTR_W-1:0];
    assign wr_idx         = wr_ptr_q[PTR_W-1:0];
    assign cur_bit        = pat_q[rd_idx];
    assign actual_pattern = valid_q & cur_bit;
    assign hit            = (pred_bit == actual_pattern);
    assign last_bit       = (rd_ptr_q == (wr_ptr_q - LEN_W'(1)));
    assign start_go       = (state_q != ST_PLAY) && start && !stop && (wr_ptr_q != '0);

    assign valid   = valid_q;
    assign done    = done_q;
    assign len     = wr_ptr_q;
    assign bit_cnt = bit_cnt_q;
    assign hit_cnt = hit_cnt_q;

    // Next-state, store editing, playback advance and scoring.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        valid_d   = valid_q;
        done_d    = done_q;
        bit_cnt_d = bit_cnt_q;
        hit_cnt_d = hit_cnt_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // An accepted start takes priority over clear and load.
                if (start_go) begin
                    state_d   = ST_PLAY;
                    rd_ptr_d  = '0;
                    bit_cnt_d = '0;
                    hit_cnt_d = '0;
                    done_d    = 1'b0;
                    valid_d   = 1'b1;
                end else if (clear) begin
                    wr_ptr_d = '0;
                end else if (load_en && (wr_ptr_q != FULL)) begin
                    pat_d[wr_idx] = load_bit;
                    wr_ptr_d      = wr_ptr_q + LEN_W'(1);
                end
            end

            ST_PLAY: begin
                if (stop) begin
                    // Abort: the bit on the wire this cycle is not scored.
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end else begin
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (hit && (hit_cnt_q != '1)) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                    if (!last_bit) begin
                        rd_ptr_d = rd_ptr_q + LEN_W'(1);
                    end else if (loop_en) begin
                        rd_ptr_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, store, pointer and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            bit_cnt_q <= bit_cnt_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Hits can never outrun scored bits, and valid tracks the PLAY state.
    a_hit_le_bit : assert property (@(posedge clk) disable iff (reset) hit_cnt_q <= bit_cnt_q);
    a_valid_play : assert property (@(posedge clk) disable iff (reset) valid_q == (state_q == ST_PLAY));

endmodule

// File: tb/tb_pattern_source_scorer.sv
// Self-checking bench for pattern_source_scorer (DEPTH=16, CNT_W=8).
// Reference model: a queue of stored bits plus plain counters for scoring.
module tb_pattern_source_scorer;

    localparam int DEPTH   = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       clear = 1'b0;
    logic                       load_en = 1'b0;
    logic                       load_bit = 1'b0;
    logic                       start = 1'b0;
    logic                       stop = 1'b0;
    logic                       loop_en = 1'b0;
    logic                       pred_bit = 1'b0;
    logic                       actual_pattern;
    logic                       valid;
    logic                       done;
    logic [$clog2(DEPTH+1)-1:0] len;
    logic [CNT_W-1:0]           bit_cnt;
    logic [CNT_W-1:0]           hit_cnt;

    int checks = 0;
    int passes = 0;

    bit mpat[$];
    int mhit;

    pattern_source_scorer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .load_en       (load_en),
        .load_bit      (load_bit),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .pred_bit      (pred_bit),
        .actual_pattern(actual_pattern),
        .valid         (valid),
        .done          (done),
        .len           (len),
        .bit_cnt       (bit_cnt),
        .hit_cnt       (hit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_one(input bit b);
        load_en  = 1'b1;
        load_bit = b;
        tick();
        load_en  = 1'b0;
        if (mpat.size() < DEPTH) mpat.push_back(b);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mpat.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mhit  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid, done, actual_pattern} !== 3'b000) $display("FAIL reset_flags: valid/done/actual=%b expected 000", {valid, done, actual_pattern});
        else passes++;
        checks++;
        if ({len, bit_cnt, hit_cnt} !== '0) $display("FAIL reset_counts: len=%0d bit=%0d hit=%0d expected 0", len, bit_cnt, hit_cnt);
        else passes++;
        reset = 1'b0;
        mpat.delete();
        tick();
    endtask

    task automatic test_single_pass();
        bit exp[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_clear();
        foreach (exp[i]) load_one(exp[i]);
        checks++;
        if (len !== 5'd4) $display("FAIL single_len: len=%0d expected 4", len);
        else passes++;
        loop_en  = 1'b0;
        pred_bit = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || actual_pattern !== exp[i] || done !== 1'b0)
                $display("FAIL single_bit%0d: valid=%b actual=%b done=%b expected 1 %b 0", i, valid, actual_pattern, done, exp[i]);
            else passes++;
            checks++;
            if (bit_cnt !== 8'(i)) $display("FAIL single_cnt%0d: bit_cnt=%0d expected %0d", i, bit_cnt, i);
            else passes++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || actual_pattern !== 1'b0)
            $display("FAIL single_end: done=%b valid=%b actual=%b expected 1 0 0", done, valid, actual_pattern);
        else passes++;
        checks++;
        if (bit_cnt !== 8'd4 || hit_cnt !== 8'd3) $display("FAIL single_score: bit=%0d hit=%0d expected 4 3", bit_cnt, hit_cnt);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b1 || bit_cnt !== 8'd4) $display("FAIL single_sticky: done=%b bit=%0d expected 1 4", done, bit_cnt);
        else passes++;
    endtask

    task automatic test_loop_tied();
        bit exp;
        loop_en = 1'b1;
        do_start();
        for (int i = 0; i < 10; i++) begin
            exp      = mpat[i % mpat.size()];
            pred_bit = exp;
            checks++;
            if (valid !== 1'b1 || actual_pattern !== exp || done !== 1'b0)
                $display("FAIL tied_bit%0d: valid=%b actual=%b done=%b expected 1 %b 0", i, valid, actual_pattern, done, exp);
            else passes++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (valid !== 1'b0 || done !== 1'b0 || bit_cnt !== 8'd10 || hit_cnt !== 8'd10)
            $display("FAIL tied_end: valid=%b done=%b bit=%0d hit=%0d expected 0 0 10 10", valid, done, bit_cnt, hit_cnt);
        else passes++;
    endtask

    task automatic test_random_play();
        for (int r = 0; r < 4; r++) begin
            int  n;
            int  p;
            int  scored;
            bit  ended;
            bit  exp;
            bit  le;
            do_clear();
            n = $urandom_range(2, DEPTH);
            for (int k = 0; k < n; k++) load_one(1'($urandom));
            checks++;
            if (len !== 5'(n)) $display("FAIL rand_len%0d: len=%0d expected %0d", r, len, n);
            else passes++;
            loop_en = 1'b1;
            do_start();
            p = 0;
            scored = 0;
            ended = 1'b0;
            while (!ended && scored < 200) begin
                exp      = mpat[p];
                pred_bit = 1'($urandom);
                le       = ($urandom_range(0, 3) != 0);
                loop_en  = le;
                checks++;
                if (valid !== 1'b1 || actual_pattern !== exp || bit_cnt !== 8'(sat(scored)) || hit_cnt !== 8'(sat(mhit)))
                    $display("FAIL rand_play%0d_%0d: valid=%b actual=%b bit=%0d hit=%0d expected 1 %b %0d %0d",
                             r, scored, valid, actual_pattern, bit_cnt, hit_cnt, exp, sat(scored), sat(mhit));
                else passes++;
                if (pred_bit == exp) mhit++;
                scored++;
                if (p == n - 1 && !le) ended = 1'b1;
                p = (p + 1) % n;
                tick();
            end
            if (!ended) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            checks++;
            if (valid !== 1'b0 || done !== ended || bit_cnt !== 8'(sat(scored)) || hit_cnt !== 8'(sat(mhit)))
                $display("FAIL rand_end%0d: valid=%b done=%b bit=%0d hit=%0d expected 0 %b %0d %0d",
                         r, valid, done, bit_cnt, hit_cnt, ended, sat(scored), sat(mhit));
            else passes++;
        end
        loop_en = 1'b0;
    endtask

    task automatic test_overflow();
        do_clear();
        for (int k = 0; k < 20; k++) load_one(1'($urandom));
        checks++;
        if (len !== 5'd16) $display("FAIL ovf_len: len=%0d expected 16", len);
        else passes++;
        loop_en = 1'b0;
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            pred_bit = 1'($urandom);
            checks++;
            if (valid !== 1'b1 || actual_pattern !== mpat[i])
                $display("FAIL ovf_bit%0d: valid=%b actual=%b expected 1 %b", i, valid, actual_pattern, mpat[i]);
            else passes++;
            if (pred_bit == mpat[i]) mhit++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || bit_cnt !== 8'd16 || hit_cnt !== 8'(mhit))
            $display("FAIL ovf_end: done=%b valid=%b bit=%0d hit=%0d expected 1 0 16 %0d", done, valid, bit_cnt, hit_cnt, mhit);
        else passes++;
    endtask

    task automatic test_empty_start();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        mpat.delete();
        tick();
        do_start();
        checks++;
        if (valid !== 1'b0 || done !== 1'b0 || bit_cnt !== 8'd0 || len !== 5'd0)
            $display("FAIL empty_start: valid=%b done=%b bit=%0d len=%0d expected 0 0 0 0", valid, done, bit_cnt, len);
        else passes++;
        load_one(1'b1);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (valid !== 1'b0 || len !== 5'd1) $display("FAIL start_with_stop: valid=%b len=%0d expected 0 1", valid, len);
        else passes++;
    endtask

    task automatic test_clear_reload();
        load_one(1'b1);
        clear    = 1'b1;
        load_en  = 1'b1;
        load_bit = 1'b1;
        tick();
        clear    = 1'b0;
        load_en  = 1'b0;
        mpat.delete();
        checks++;
        if (len !== 5'd0) $display("FAIL clear_wins: len=%0d expected 0", len);
        else passes++;
        load_one(1'b0);
        load_one(1'b1);
        loop_en  = 1'b0;
        pred_bit = 1'b0;
        do_start();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid !== 1'b1 || actual_pattern !== mpat[i])
                $display("FAIL reload_bit%0d: valid=%b actual=%b expected 1 %b", i, valid, actual_pattern, mpat[i]);
            else passes++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || bit_cnt !== 8'd2 || hit_cnt !== 8'd1)
            $display("FAIL reload_end: done=%b bit=%0d hit=%0d expected 1 2 1", done, bit_cnt, hit_cnt);
        else passes++;
        load_one(1'b1);
        checks++;
        if (done !== 1'b1 || len !== 5'd3) $display("FAIL done_load: done=%b len=%0d expected 1 3", done, len);
        else passes++;
    endtask

    task automatic test_stop();
        do_clear();
        for (int k = 0; k < 4; k++) load_one(1'($urandom));
        loop_en = 1'b0;
        do_start();
        for (int i = 0; i < 2; i++) begin
            pred_bit = 1'($urandom);
            if (pred_bit == mpat[i]) mhit++;
            load_en  = (i == 1);
            load_bit = 1'b1;
            tick();
        end
        load_en = 1'b0;
        checks++;
        if (len !== 5'd4 || actual_pattern !== mpat[2]) $display("FAIL play_load_ignored: len=%0d actual=%b expected 4 %b", len, actual_pattern, mpat[2]);
        else passes++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (valid !== 1'b0 || actual_pattern !== 1'b0 || done !== 1'b0 || bit_cnt !== 8'd2 || hit_cnt !== 8'(mhit))
            $display("FAIL stop_end: valid=%b actual=%b done=%b bit=%0d hit=%0d expected 0 0 0 2 %0d",
                     valid, actual_pattern, done, bit_cnt, hit_cnt, mhit);
        else passes++;
        do_start();
        checks++;
        if (valid !== 1'b1 || actual_pattern !== mpat[0] || bit_cnt !== 8'd0 || hit_cnt !== 8'd0)
            $display("FAIL restart: valid=%b actual=%b bit=%0d hit=%0d expected 1 %b 0 0", valid, actual_pattern, bit_cnt, hit_cnt, mpat[0]);
        else passes++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        loop_en = 1'b1;
        do_start();
        tick();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({valid, done, actual_pattern} !== 3'b000 || len !== 5'd0 || bit_cnt !== 8'd0 || hit_cnt !== 8'd0)
            $display("FAIL async_reset: valid/done/actual=%b len=%0d bit=%0d hit=%0d expected 000 0 0 0",
                     {valid, done, actual_pattern}, len, bit_cnt, hit_cnt);
        else passes++;
        tick();
        reset   = 1'b0;
        loop_en = 1'b0;
        mpat.delete();
        tick();
    endtask

    task automatic test_saturation();
        bit exp;
        for (int k = 0; k < 5; k++) load_one(1'($urandom));
        loop_en = 1'b1;
        do_start();
        for (int i = 0; i < 300; i++) begin
            exp      = mpat[i % mpat.size()];
            pred_bit = ~exp;
            checks++;
            if (actual_pattern !== exp || bit_cnt !== 8'(sat(i)))
                $display("FAIL sat_cyc%0d: actual=%b bit=%0d expected %b %0d", i, actual_pattern, bit_cnt, exp, sat(i));
            else passes++;
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (bit_cnt !== 8'd255 || hit_cnt !== 8'd0) $display("FAIL sat_end: bit=%0d hit=%0d expected 255 0", bit_cnt, hit_cnt);
        else passes++;
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_loop_tied();
        test_random_play();
        test_overflow();
        test_empty_start();
        test_clear_reload();
        test_stop();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
